// File: rtl/top_core.sv
// Mixing shift chain of 103-bit stages plus a signed multiply-accumulate, all exposed on one observation bus.
// Build option: define TOP_CORE_ACC_SAT_EN to make the accumulator saturate instead of wrapping.
module top_core #(
    parameter int DEPTH = 14,
    parameter int ACC_W = 48
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [24:0]                  wire4,
    input  logic [8:0]                   wire3,
    input  logic [21:0]                  wire2,
    input  logic [25:0]                  wire1,
    input  logic [20:0]                  wire0,
    output logic [ACC_W+DEPTH*103-1:0]   y
);

    localparam int SW = 103;

    logic [SW-1:0]    in_vec;
    logic [SW-1:0]    stage [DEPTH];
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic [31:0]      prod;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] acc_next;

    assign in_vec = {wire4, wire3, wire2, wire1, wire0};

    // Operands are widened to 32 bits up front; the low 32 bits of the product are exact
    // because a 22-bit signed times a 10-bit signed value always fits in 32 bits.
    assign mul_a    = {{10{wire2[21]}}, wire2};
    assign mul_b    = {23'b0, wire3};
    assign prod     = mul_a * mul_b;
    assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
    assign acc_sum  = acc + prod_ext;

    always_comb begin
        acc_next = acc_sum;
`ifdef TOP_CORE_ACC_SAT_EN
        if (!acc[ACC_W-1] && !prod_ext[ACC_W-1] && acc_sum[ACC_W-1]) begin
            acc_next = {1'b0, {(ACC_W-1){1'b1}}};
        end else if (acc[ACC_W-1] && prod_ext[ACC_W-1] && !acc_sum[ACC_W-1]) begin
            acc_next = {1'b1, {(ACC_W-1){1'b0}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
            acc <= '0;
        end else begin
            stage[0] <= in_vec;
            // Each stage mixes its predecessor with a 1-bit left rotation of itself.
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1] ^ {stage[k-1][SW-2:0], stage[k-1][SW-1]};
            end
            acc <= acc_next;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_map
        assign y[SW*g +: SW] = stage[g];
    end
    assign y[ACC_W+DEPTH*SW-1 -: ACC_W] = acc;

endmodule

// File: tb/tb_top_core.sv
// Directed self-checking bench for top_core: reset, zero input, impulse propagation, mapping, MAC and async reset.
module tb_top_core;

    localparam int DEPTH = 14;
    localparam int ACC_W = 48;
    localparam int YW    = ACC_W + DEPTH*103;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [24:0]   wire4 = '0;
    logic [8:0]    wire3 = '0;
    logic [21:0]   wire2 = '0;
    logic [25:0]   wire1 = '0;
    logic [20:0]   wire0 = '0;
    logic [YW-1:0] y;

    int total = 0;
    int bad   = 0;

    top_core #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wire4(wire4), .wire3(wire3), .wire2(wire2), .wire1(wire1), .wire0(wire0),
        .y(y)
    );

    always #5 clk = ~clk;

    function automatic logic [102:0] stage_of(input int k);
        return y[103*k +: 103];
    endfunction

    function automatic logic [47:0] acc_of();
        return y[YW-1 -: ACC_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [24:0] w4, input logic [8:0] w3,
                                 input logic [21:0] w2, input logic [25:0] w1,
                                 input logic [20:0] w0);
        wire4 = w4; wire3 = w3; wire2 = w2; wire1 = w1; wire0 = w0;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkZero(input string tag);
        total++;
        assert (y === '0) else begin
            bad++;
            $error("[TB] FAIL %s observed_set_bits=%0d expected_set_bits=0", tag, $countones(y));
        end
    endtask

    logic [102:0] vec;
    logic [102:0] vec_mix;

    initial begin
        // Reset held: y must be zero across clock edges.
        #3;
        checkZero("reset_async");
        for (int i = 0; i < 3; i++) begin
            tick();
            checkZero("reset_held");
        end

        // Zero input after release is a fixed point.
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkZero("zero_input");
        end

        // Impulse on wire0: stage k holds the binomial pattern (1+x)^k.
        applyStimulus('0, '0, '0, '0, 21'h1);
        tick();
        checkOutput("impulse_s0", 128'(stage_of(0)), 128'h1);
        applyStimulus('0, '0, '0, '0, '0);
        tick();
        checkOutput("impulse_s1", 128'(stage_of(1)), 128'h3);
        checkOutput("impulse_s0_clear", 128'(stage_of(0)), 128'h0);
        tick();
        checkOutput("impulse_s2", 128'(stage_of(2)), 128'h5);
        checkOutput("impulse_s1_clear", 128'(stage_of(1)), 128'h0);
        tick();
        checkOutput("impulse_s3", 128'(stage_of(3)), 128'hF);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("impulse_s13", 128'(stage_of(13)), 128'h3333);
        checkOutput("impulse_acc", 128'(acc_of()), 128'h0);

        // MSB of wire4 must rotate into bit 0 of the next stage.
        applyStimulus(25'h1000000, '0, '0, '0, '0);
        tick();
        applyStimulus('0, '0, '0, '0, '0);
        checkOutput("msb_s0", 128'(stage_of(0)), {25'h0, 1'b1, 102'h0});
        tick();
        checkOutput("msb_wrap_s1", 128'(stage_of(1)), {25'h0, 1'b1, 101'h0, 1'b1});

        // Field placement of the captured input vector.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        applyStimulus(25'h1234567, 9'h0A5, 22'h2ABCDE, 26'h3C0FFEE, 21'h1F00F);
        vec = {25'h1234567, 9'h0A5, 22'h2ABCDE, 26'h3C0FFEE, 21'h1F00F};
        vec_mix = vec ^ {vec[101:0], vec[102]};
        tick();
        applyStimulus('0, '0, '0, '0, '0);
        checkOutput("map_s0", 128'(stage_of(0)), 128'(vec));
        tick();
        checkOutput("map_s1", 128'(stage_of(1)), 128'(vec_mix));

        // Multiply-accumulate from a clean reset.
        rst_n = 1'b0;
        #1;
        checkOutput("mac_reset_acc", 128'(acc_of()), 128'h0);
        rst_n = 1'b1;
        applyStimulus('0, 9'h002, 22'h3FFFFF, '0, '0);
        tick();
        checkOutput("mac_step1", 128'(acc_of()), 128'hFFFF_FFFF_FFFE);
        tick();
        checkOutput("mac_step2", 128'(acc_of()), 128'hFFFF_FFFF_FFFC);
        tick();
        checkOutput("mac_step3", 128'(acc_of()), 128'hFFFF_FFFF_FFFA);
        applyStimulus('0, 9'h1FF, 22'h3FFFFF, '0, '0);
        tick();
        checkOutput("mac_wire3_unsigned", 128'(acc_of()), 128'hFFFF_FFFF_FDFB);
        applyStimulus('0, 9'h1FF, 22'h1FFFFF, '0, '0);
        tick();
        checkOutput("mac_max_pos", 128'(acc_of()), 128'h0000_3FDF_FBFC);
        applyStimulus('0, 9'h1FF, 22'h200000, '0, '0);
        tick();
        checkOutput("mac_max_neg", 128'(acc_of()), 128'hFFFF_FFFF_FBFC);
        applyStimulus('0, '0, '0, '0, '0);
        tick();
        checkOutput("mac_hold_zero_prod", 128'(acc_of()), 128'hFFFF_FFFF_FBFC);

        // Asynchronous reset in the middle of a busy run.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(25'($urandom), 9'($urandom), 22'($urandom), 26'($urandom),
                          21'($urandom) | 21'h1);
            tick();
        end
        total++;
        assert (y !== '0) else begin
            bad++;
            $error("[TB] FAIL busy_nonzero observed_set_bits=0 expected_set_bits=nonzero");
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkZero("async_reset_midcycle");
        tick();
        checkZero("async_reset_held_edge");
        applyStimulus('0, '0, '0, '0, 21'h1);
        rst_n = 1'b1;
        tick();
        applyStimulus('0, '0, '0, '0, '0);
        checkOutput("resume_s0", 128'(stage_of(0)), 128'h1);
        checkOutput("resume_s1", 128'(stage_of(1)), 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
